// File: rtl/ifetch.sv
// Instruction fetch: drives word addresses into imem, absorbs its one-cycle read
// latency and hands {pc, word, fault} to decode through a 2-entry valid/ready buffer.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_write_en,
  output logic [31:0] imem_write_data,
  input  logic [31:0] imem_read_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        halted
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic [1:0]  r_occ;

  logic [31:0] r_pc0;
  logic [31:0] r_pc1;
  logic [31:0] r_data0;
  logic [31:0] r_data1;
  logic        r_fault0;
  logic        r_fault1;

  logic        w_pop;
  logic        w_issue;
  logic        w_push;
  logic        w_fault_in;
  logic        w_halted;
  logic        w_wr_head;
  logic [1:0]  w_committed;
  logic [31:0] w_pc_inc;

  assign w_halted   = (r_state == ST_HALT);
  assign w_pop      = inst_valid & inst_ready;
  assign w_fault_in = (imem_read_data == 32'hFFFF_FFFF);
  assign w_pc_inc   = r_fetch_pc + 32'd4;

  // Slots already spoken for after this cycle's pop: buffered plus the response in flight.
  assign w_committed = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue     = fetch_en & ~w_halted & ~redirect_valid & (w_committed < 2'd2);

  // Once halted, the fetch issued alongside the faulting one is discarded.
  assign w_push    = r_inflight & ~redirect_valid & ~w_halted;
  assign w_wr_head = (r_occ == {1'b0, w_pop});

  assign imem_addr       = r_fetch_pc;
  assign imem_write_en   = 1'b0;
  assign imem_write_data = '0;

  assign inst_valid = (r_occ != 2'd0);
  assign inst_pc    = r_pc0;
  assign inst_data  = r_data0;
  assign inst_fault = r_fault0;
  assign halted     = w_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_occ         <= 2'd0;
      r_state       <= ST_RUN;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
      end

      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= w_pc_inc;
      end

      if (redirect_valid) begin
        r_occ <= 2'd0;
      end else begin
        r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      end

      if (redirect_valid) begin
        r_state <= ST_RUN;
      end else if (w_push && w_fault_in) begin
        r_state <= ST_HALT;
      end
    end
  end

  // Two-slot shift buffer: slot 0 is always the head presented to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc0    <= '0;
      r_pc1    <= '0;
      r_data0  <= '0;
      r_data1  <= '0;
      r_fault0 <= 1'b0;
      r_fault1 <= 1'b0;
    end else begin
      if (w_pop) begin
        r_pc0    <= r_pc1;
        r_data0  <= r_data1;
        r_fault0 <= r_fault1;
      end
      if (w_push) begin
        if (w_wr_head) begin
          r_pc0    <= r_inflight_pc;
          r_data0  <= imem_read_data;
          r_fault0 <= w_fault_in;
        end else begin
          r_pc1    <= r_inflight_pc;
          r_data1  <= imem_read_data;
          r_fault1 <= w_fault_in;
        end
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_occ == 2'd2)));

  a_occ_range: assert property (@(posedge clk) disable iff (rst)
    (r_occ != 2'd3));

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the initiator side of the `imem` word-read port. Holds the fetch PC, drives word-aligned byte addresses into `imem` and absorbs its one-cycle registered read latency. Delivers `{pc, instruction, fault}` to decode through a 2-entry buffer with valid/ready backpressure. Handles redirects (branch/jump/trap) by flushing stale fetches, and halts on an `imem` bad-access response.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `fetch_en`  in  1: permits new fetches to issue.
- `redirect_valid`  in  1: load a new fetch PC this cycle.
- `redirect_pc`  in  32: target byte address; not required to be aligned.
- `imem_addr`  out  32: byte address to `imem`; equals the internal fetch PC.
- `imem_write_en`  out  1: constant 0.
- `imem_write_data`  out  32: constant 0.
- `imem_read_data`  in  32: `imem` word, valid the cycle after an address is presented; 32'hFFFF_FFFF marks a bad access.
- `inst_valid`  out  1: buffer head valid.
- `inst_ready`  in  1: consumer accepts the head.
- `inst_data`  out  32: instruction word.
- `inst_pc`  out  32: byte address of `inst_data`.
- `inst_fault`  out  1: head came from a bad access.
- `halted`  out  1: fetch stopped after a fault.

## Operation
- State: `fetch_pc`, `inflight` flag, `inflight_pc`, 2-entry FIFO of {pc, data, fault} with occupancy `occ` in 0..2, `halted`.
- `pop` = `inst_valid` & `inst_ready`.
- Issue condition: `fetch_en` & !`halted` & !`redirect_valid` & (`occ` + `inflight` − `pop`) < 2.
- On issue at edge: `inflight` <= 1, `inflight_pc` <= `fetch_pc`, `fetch_pc` <= `fetch_pc` + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Without issue, `inflight` <= 0 and `fetch_pc` holds. `imem` still reads `imem_addr`; that data is ignored.
- Response capture:
  - When `inflight` = 1 and no redirect, push {`inflight_pc`, `imem_read_data`, fault = (`imem_read_data` == 32'hFFFF_FFFF)}.
  - A push with fault = 1 sets `halted`. Later fetches are suppressed; entries already buffered still drain in order.
- Push and pop in the same cycle are both performed. The credit rule guarantees a push never hits a full FIFO. An overflow is a design error; flag it with a simulation assertion.
- Redirect (highest priority):
  - On `redirect_valid`, any `pop` that cycle completes normally.
  - The FIFO is then flushed (`occ` <= 0), `inflight` <= 0 (that response is dropped), `halted` <= 0, and `fetch_pc` <= `redirect_pc`.
  - Issue resumes the next cycle, subject to `fetch_en`.
- A misaligned `redirect_pc` is fetched as-is. `imem` returns 32'hFFFF_FFFF, which produces a fault entry and halts fetch.
- `fetch_en` = 0 blocks issue only. An in-flight response still lands and redirects still apply.
- States: RUN (`halted` = 0) and HALT (`halted` = 1).
  - RUN→HALT: fault push.
  - HALT→RUN: `redirect_valid` or `rst`.

## Timing
- Reset values: `imem_addr` = `RESET_PC`, `inst_valid` = 0, `inst_data` = 0, `inst_pc` = 0, `inst_fault` = 0, `halted` = 0, `imem_write_en` = 0, `imem_write_data` = 0; `occ` = 0, `inflight` = 0.
- Reset asserted mid-operation discards all buffered and in-flight fetches immediately.
- Cycle 0 is the first cycle after reset release. `imem_addr` = `RESET_PC` is issued in cycle 0, data is captured at the end of cycle 1, and `inst_valid` = 1 in cycle 2. Address-to-valid latency is 2 cycles.
- Throughput with `inst_ready` held 1: one instruction per cycle, PCs consecutive.
- Backpressure: at most one extra word is accepted after `inst_ready` drops. Occupancy never exceeds 2.
- Redirect asserted in cycle N: `imem_addr` = `redirect_pc` in cycle N+1, first new `inst_valid` in cycle N+3. `inst_valid` = 0 in cycles N+1 and N+2.
- Outputs `inst_*` come straight from the FIFO head register. There is no combinational path from `imem_read_data` to `inst_*`. `inst_ready` affects only issue and pop.

## Test plan
- Reset release, `RESET_PC` = 0, `imem` words 0x00000013+i at address 4i, `inst_ready` = 1 -> first `inst_valid` in cycle 2 with pc 0, data 0x13; then pc 4, 8, 12 on consecutive cycles.
- Stream running, `inst_ready` = 0 for 5 cycles -> `inst_valid` stays 1 with `inst_pc` constant, `imem_addr` holds, no PC is skipped or duplicated after `inst_ready` returns to 1.
- `redirect_valid` with pc 0x40 while 2 entries are buffered and 1 is in flight -> `inst_valid` = 0 for 2 cycles, then the next accepted `inst_pc` = 0x40, then 0x44; no stale PC appears.
- Fetch runs past the last valid `imem` word -> entry with data 0xFFFFFFFF and `inst_fault` = 1, `halted` = 1, no further issue. A subsequent redirect to 0 clears `halted` and resumes at pc 0.
- `redirect_pc` = 0x6 -> single entry with pc 0x6, `inst_fault` = 1, `halted` = 1.
- `RESET_PC` = 32'hFFFF_FFF8 with `imem` stubbed to return valid data -> PCs FFFFFFF8, FFFFFFFC, 0, 4 in order. Reset asserted mid-stream -> `inst_valid` = 0 immediately and `imem_addr` = `RESET_PC`.
